// File: rtl/nmr_pkg.sv
// Shared types for the N-modular-redundancy vote controller.
package nmr_pkg;

    localparam int MAX_CH = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        COMPARE,
        DONE,
        FAULT
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  winner;
        logic              has_maj;
        logic              all_eq;
        logic [MAX_CH-1:0] mask;
    } vote_result_t;

endpackage

// File: rtl/nmr_majority.sv
// Combinational agree-count majority vote over CHANNELS latched words.
module nmr_majority
    import nmr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 3
) (
    input  logic [CHANNELS*WIDTH-1:0] i_words,
    output vote_result_t              o_result
);

    logic [WIDTH-1:0] w_word [CHANNELS];
    logic [3:0]       w_agree [CHANNELS];
    logic [WIDTH-1:0] w_win_word;
    logic             w_found;
    logic [IDX_W-1:0] w_winner;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign w_word[g] = i_words[g*WIDTH +: WIDTH];
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_agree[i] = '0;
            for (int j = 0; j < CHANNELS; j++) begin
                if (w_word[i] == w_word[j]) begin
                    w_agree[i] = w_agree[i] + 4'd1;
                end
            end
        end
    end

    // Lowest-index channel holding a strict majority wins.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && (2 * int'(w_agree[i]) > CHANNELS)) begin
                w_found    = 1'b1;
                w_winner   = IDX_W'(i);
                w_win_word = w_word[i];
            end
        end
    end

    always_comb begin
        o_result         = '0;
        o_result.winner  = w_winner;
        o_result.has_maj = w_found;
        o_result.all_eq  = (int'(w_agree[0]) == CHANNELS);
        for (int j = 0; j < CHANNELS; j++) begin
            o_result.mask[j] = w_found && (w_word[j] != w_win_word);
        end
    end

endmodule

// File: rtl/nmr_vote_sm.sv
// NMR compare/vote controller: collects one word per channel, votes, and reports
// the agreed word plus dissent, timeout and no-majority faults with a sticky interrupt.
module nmr_vote_sm
    import nmr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 3,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       data_set,
    input  logic                      int_ack,
    output logic [WIDTH-1:0]          voted_data,
    output logic                      voted_valid,
    output logic                      isMatch,
    output logic [CHANNELS-1:0]       fault_mask,
    output logic                      timeout_flag,
    output logic                      nomaj_flag,
    output logic [CNT_W-1:0]          err_count,
    output logic                      interupt_prompt
);

    localparam int                  TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CHANNELS-1:0] ALL_CH = '1;

    state_e               r_state;
    state_e               w_next;
    logic [WIDTH-1:0]     r_word [CHANNELS];
    logic [CHANNELS-1:0]  r_valid;
    logic [TCNT_W-1:0]    r_tcnt;
    logic [CHANNELS*WIDTH-1:0] w_words;
    vote_result_t         w_vote;
    logic [WIDTH-1:0]     w_win_word;

    logic                 w_capture;
    logic                 w_round_end;
    logic                 w_compare;
    logic                 w_timeout_hit;
    logic                 w_vote_fault;
    logic                 w_fault_evt;

    logic [WIDTH-1:0]     r_voted_data;
    logic                 r_voted_valid;
    logic                 r_is_match;
    logic [CHANNELS-1:0]  r_fault_mask;
    logic                 r_timeout_flag;
    logic                 r_nomaj_flag;
    logic [CNT_W-1:0]     r_err_count;
    logic                 r_irq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign w_words[g*WIDTH +: WIDTH] = r_word[g];
    end

    nmr_majority #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_majority (
        .i_words  (w_words),
        .o_result (w_vote)
    );

    always_comb begin
        w_win_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_vote.winner == IDX_W'(i)) begin
                w_win_word = r_word[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The timeout is only reached with channels still missing; a full bitmap goes to vote.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|data_set) w_next = COLLECT;
            COLLECT: begin
                if (r_valid == ALL_CH) begin
                    w_next = COMPARE;
                end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    w_next = FAULT;
                end
            end
            COMPARE: w_next = w_vote.has_maj ? DONE : FAULT;
            DONE:    w_next = IDLE;
            FAULT:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_capture     = (r_state == IDLE) || (r_state == COLLECT);
        w_round_end   = (r_state == DONE) || (r_state == FAULT);
        w_compare     = (r_state == COMPARE);
        w_timeout_hit = (r_state == COLLECT) && (r_valid != ALL_CH)
                        && (r_tcnt == TCNT_W'(TIMEOUT - 1));
        w_vote_fault  = w_compare
                        && (!w_vote.has_maj || (w_vote.mask[CHANNELS-1:0] != '0));
        w_fault_evt   = w_timeout_hit || w_vote_fault;
    end

    // First write wins: a channel already latched this round ignores further sets.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_word[i] <= '0;
            end
        end else if (w_round_end) begin
            r_valid <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (data_set[i] && !r_valid[i]) begin
                    r_valid[i] <= 1'b1;
                    r_word[i]  <= data_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state != COLLECT)) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // A fault registered in the same cycle as int_ack takes priority over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_voted_data   <= '0;
            r_voted_valid  <= 1'b0;
            r_is_match     <= 1'b0;
            r_fault_mask   <= '0;
            r_timeout_flag <= 1'b0;
            r_nomaj_flag   <= 1'b0;
            r_err_count    <= '0;
            r_irq          <= 1'b0;
        end else begin
            r_voted_valid <= w_compare && w_vote.has_maj;
            if (w_compare) begin
                r_is_match   <= w_vote.all_eq;
                r_fault_mask <= w_vote.has_maj ? w_vote.mask[CHANNELS-1:0] : ALL_CH;
                if (w_vote.has_maj) begin
                    r_voted_data <= w_win_word;
                end
            end
            if (w_timeout_hit) begin
                r_fault_mask <= ~r_valid;
            end

            if (w_timeout_hit) begin
                r_timeout_flag <= 1'b1;
            end else if (int_ack) begin
                r_timeout_flag <= 1'b0;
            end

            if (w_compare && !w_vote.has_maj) begin
                r_nomaj_flag <= 1'b1;
            end else if (int_ack) begin
                r_nomaj_flag <= 1'b0;
            end

            if (w_fault_evt) begin
                r_irq       <= 1'b1;
                r_err_count <= sat_inc(r_err_count);
            end else if (int_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign voted_data      = r_voted_data;
    assign voted_valid     = r_voted_valid;
    assign isMatch         = r_is_match;
    assign fault_mask      = r_fault_mask;
    assign timeout_flag    = r_timeout_flag;
    assign nomaj_flag      = r_nomaj_flag;
    assign err_count       = r_err_count;
    assign interupt_prompt = r_irq;

endmodule
